// File: rtl/mm_job_sequencer.sv
// Job controller for a sum_stationary array: buffers A/B, clears the array, feeds N beats,
// waits for completion and returns C row by row. Optional WAIT timeout under MM_SEQ_TIMEOUT_EN.
module mm_job_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int N            = 4,
  parameter int C_DATA_WIDTH = 2*DATA_WIDTH+$clog2(N),
  parameter int WAIT_LIMIT   = 4*N
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                op_we_i,
  input  logic                                op_sel_i,
  input  logic [$clog2(N*N)-1:0]              op_addr_i,
  input  logic [DATA_WIDTH-1:0]               op_wdata_i,
  input  logic                                start_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                error_o,
  output logic                                arr_reset_o,
  output logic                                arr_valid_o,
  output logic [N-1:0][DATA_WIDTH-1:0]        arr_a_o,
  output logic [N-1:0][DATA_WIDTH-1:0]        arr_b_o,
  input  logic                                arr_valid_i,
  input  logic [N*N-1:0][C_DATA_WIDTH-1:0]    arr_c_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [$clog2(N)-1:0]                res_row_o,
  output logic [N-1:0][C_DATA_WIDTH-1:0]      res_data_o
);

  localparam int AW = $clog2(N*N);
  localparam int KW = $clog2(N);

  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_FEED, ST_WAIT, ST_DRAIN} state_t;

  state_t                       state_r;
  logic [KW-1:0]                k_r;
  logic [KW-1:0]                r_r;
  logic [KW-1:0]                beat_idx_s;
  logic [DATA_WIDTH-1:0]        a_mem_r [N*N];
  logic [DATA_WIDTH-1:0]        b_mem_r [N*N];
  logic [N-1:0][DATA_WIDTH-1:0] feed_a_s;
  logic [N-1:0][DATA_WIDTH-1:0] feed_b_s;
  logic                         error_r;

  assign arr_reset_o = reset_i | (state_r == ST_CLEAR);
  assign res_row_o   = r_r;
  assign error_o     = error_r;

  // Operand buffers: host writes land only while idle
  always_ff @(posedge clk_i) begin
    if (state_r == ST_IDLE && op_we_i) begin
      if (op_sel_i) b_mem_r[op_addr_i] <= op_wdata_i;
      else          a_mem_r[op_addr_i] <= op_wdata_i;
    end
  end

  // Operands for the beat that the next edge puts on the array bus
  always_comb begin
    beat_idx_s = '0;
    if (state_r == ST_FEED && k_r != KW'(N-1)) beat_idx_s = k_r + 1'b1;
    else                                       beat_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      feed_a_s[i] = a_mem_r[AW'(i*N) + AW'(beat_idx_s)];
      feed_b_s[i] = b_mem_r[AW'(beat_idx_s) * AW'(N) + AW'(i)];
    end
  end

  // The array holds c_o while valid_o is high, so the row is read straight through
  always_comb begin
    for (int j = 0; j < N; j++) res_data_o[j] = arr_c_i[AW'(r_r) * AW'(N) + AW'(j)];
  end

`ifdef MM_SEQ_TIMEOUT_EN
  localparam int WCW = $clog2(WAIT_LIMIT+1);
  logic [WCW-1:0] wait_cnt_r;
  logic           tmo_r;
`endif

  // Job sequencing FSM with registered array and result handshake outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      k_r         <= '0;
      r_r         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      arr_valid_o <= 1'b0;
      arr_a_o     <= '0;
      arr_b_o     <= '0;
      res_valid_o <= 1'b0;
`ifdef MM_SEQ_TIMEOUT_EN
      wait_cnt_r  <= '0;
      tmo_r       <= 1'b0;
      error_r     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_r <= ST_CLEAR;
            busy_o  <= 1'b1;
          end
        end
        ST_CLEAR: begin
`ifdef MM_SEQ_TIMEOUT_EN
          if (tmo_r) begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
            tmo_r   <= 1'b0;
          end else
`endif
          begin
            state_r     <= ST_FEED;
            k_r         <= '0;
            arr_valid_o <= 1'b1;
            arr_a_o     <= feed_a_s;
            arr_b_o     <= feed_b_s;
          end
        end
        ST_FEED: begin
          if (k_r == KW'(N-1)) begin
            state_r     <= ST_WAIT;
            arr_valid_o <= 1'b0;
            arr_a_o     <= '0;
            arr_b_o     <= '0;
`ifdef MM_SEQ_TIMEOUT_EN
            wait_cnt_r  <= '0;
`endif
          end else begin
            k_r     <= k_r + 1'b1;
            arr_a_o <= feed_a_s;
            arr_b_o <= feed_b_s;
          end
        end
        ST_WAIT: begin
          if (arr_valid_i) begin
            state_r     <= ST_DRAIN;
            r_r         <= '0;
            res_valid_o <= 1'b1;
          end
`ifdef MM_SEQ_TIMEOUT_EN
          else if (wait_cnt_r == WCW'(WAIT_LIMIT-1)) begin
            state_r <= ST_CLEAR;
            error_r <= 1'b1;
            tmo_r   <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
`endif
        end
        ST_DRAIN: begin
          if (res_ready_i) begin
            if (r_r == KW'(N-1)) begin
              state_r     <= ST_IDLE;
              r_r         <= '0;
              res_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              r_r <= r_r + 1'b1;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_o      <= 1'b0;
          arr_valid_o <= 1'b0;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifndef MM_SEQ_TIMEOUT_EN
  assign error_r = 1'b0;
`endif

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Randomised bench for mm_job_sequencer against a matrix-product reference, with a
// behavioural stand-in for the sum_stationary array.
module tb_mm_job_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 2*DW + $clog2(N);

  logic                     clk_i = 1'b0;
  logic                     reset_i;
  logic                     op_we_i, op_sel_i, start_i, res_ready_i;
  logic [$clog2(N*N)-1:0]   op_addr_i;
  logic [DW-1:0]            op_wdata_i;
  logic                     busy_o, done_o, error_o, arr_reset_o, arr_valid_o, res_valid_o;
  logic [N-1:0][DW-1:0]     arr_a_o, arr_b_o;
  logic                     arr_valid_s;
  logic [N*N-1:0][CW-1:0]   arr_c_s;
  logic [$clog2(N)-1:0]     res_row_o;
  logic [N-1:0][CW-1:0]     res_data_o;

  int  n_checks = 0;
  int  n_errors = 0;
  int  a_m [N][N];
  int  b_m [N][N];
  int  beats_m = 0;
  int  dly_m = 0;
  bit  arr_hold = 1'b0;

  always #5 clk_i = ~clk_i;

  mm_job_sequencer #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .op_we_i(op_we_i), .op_sel_i(op_sel_i), .op_addr_i(op_addr_i), .op_wdata_i(op_wdata_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .arr_reset_o(arr_reset_o), .arr_valid_o(arr_valid_o), .arr_a_o(arr_a_o), .arr_b_o(arr_b_o),
    .arr_valid_i(arr_valid_s), .arr_c_i(arr_c_s),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_row_o(res_row_o), .res_data_o(res_data_o)
  );

  // Array stand-in: accumulates outer products, reports done 3N cycles after start, holds C
  always @(posedge clk_i) begin
    if (arr_reset_o) begin
      arr_c_s     <= '0;
      beats_m     <= 0;
      dly_m       <= 0;
      arr_valid_s <= 1'b0;
    end else if (arr_valid_o && beats_m < N) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          arr_c_s[i*N+j] <= arr_c_s[i*N+j] + CW'(arr_a_o[i]) * CW'(arr_b_o[j]);
      beats_m <= beats_m + 1;
      if (beats_m == N-1) dly_m <= 2*N-2;
    end else if (dly_m > 1) begin
      dly_m <= dly_m - 1;
    end else if (dly_m == 1 && !arr_hold) begin
      arr_valid_s <= 1'b1;
      dly_m       <= 0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_ops();
    for (int s = 0; s < 2; s++)
      for (int idx = 0; idx < N*N; idx++) begin
        @(negedge clk_i);
        op_we_i    = 1'b1;
        op_sel_i   = s[0];
        op_addr_i  = idx[$clog2(N*N)-1:0];
        op_wdata_i = (s == 0) ? DW'(a_m[idx/N][idx%N]) : DW'(b_m[idx/N][idx%N]);
      end
    @(negedge clk_i);
    op_we_i = 1'b0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = int'($urandom_range(0, 255));
        b_m[i][j] = int'($urandom_range(0, 255));
      end
  endtask

  // bp: stall row 1 for three cycles; inj: start/write during FEED; late_wr: write A[0][0] with start
  task automatic run_job(input bit bp, input bit inj, input bit late_wr);
    int  c_e [N][N];
    int  cyc, row, stall;
    bit  first, fin;
    if (late_wr) a_m[0][0] = int'($urandom_range(0, 255));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_e[i][j] = 0;
        for (int k = 0; k < N; k++) c_e[i][j] += a_m[i][k] * b_m[k][j];
      end
    @(negedge clk_i);
    start_i     = 1'b1;
    res_ready_i = 1'b1;
    if (late_wr) begin
      op_we_i = 1'b1; op_sel_i = 1'b0; op_addr_i = '0; op_wdata_i = DW'(a_m[0][0]);
    end
    cyc = 0; row = 0; stall = 0; first = 1'b0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      op_we_i = 1'b0;
      if (inj && cyc == 3) begin
        start_i = 1'b1; op_we_i = 1'b1; op_sel_i = 1'b1; op_addr_i = 4'd5;
        op_wdata_i = DW'(b_m[1][1] ^ 255);
      end
      if (res_valid_o) begin
        if (!first) begin
          first = 1'b1;
          chk("first_valid_cycle", cyc, 3*N+1);
        end
        chk("res_row", int'(res_row_o), row);
        for (int j = 0; j < N; j++) chk("res_data", int'(res_data_o[j]), c_e[row][j]);
        if (bp && row == 1 && stall < 3) begin
          res_ready_i = 1'b0;
          stall++;
        end else begin
          res_ready_i = 1'b1;
          row++;
          if (row == N) fin = 1'b1;
        end
      end
    end
    if (!fin) chk("job_budget_expired", cyc, -1);
    @(negedge clk_i);
    chk("done_pulse", int'(done_o), 1);
    chk("busy_after_job", int'(busy_o), 0);
    chk("res_valid_after_job", int'(res_valid_o), 0);
    @(negedge clk_i);
    chk("done_one_cycle", int'(done_o), 0);
    chk("busy_stays_idle", int'(busy_o), 0);
  endtask

  initial begin
    reset_i = 1'b1; op_we_i = 1'b0; op_sel_i = 1'b0; op_addr_i = '0; op_wdata_i = '0;
    start_i = 1'b0; res_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_error", int'(error_o), 0);
    chk("rst_arr_valid", int'(arr_valid_o), 0);
    chk("rst_res_valid", int'(res_valid_o), 0);
    chk("rst_arr_a", int'(arr_a_o), 0);
    chk("rst_arr_b", int'(arr_b_o), 0);
    chk("rst_arr_reset", int'(arr_reset_o), 1);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("idle_arr_reset", int'(arr_reset_o), 0);

    // identity times B gives B
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = N*i + j + 1;
      end
    load_ops();
    run_job(1'b0, 1'b0, 1'b0);

    // saturation, then small values to prove the array was cleared
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin a_m[i][j] = 255; b_m[i][j] = 255; end
    load_ops();
    run_job(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin a_m[i][j] = 1; b_m[i][j] = 1; end
    load_ops();
    run_job(1'b0, 1'b0, 1'b0);

    rand_ops(); load_ops();
    run_job(1'b1, 1'b0, 1'b0);

    rand_ops(); load_ops();
    run_job(1'b0, 1'b1, 1'b0);
    run_job(1'b0, 1'b0, 1'b0);

    rand_ops(); load_ops();
    run_job(1'b1, 1'b0, 1'b1);

    // asynchronous reset in FEED beat k=2
    rand_ops(); load_ops();
    @(negedge clk_i);
    start_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    chk("feed_before_reset", int'(arr_valid_o), 1);
    #1 reset_i = 1'b1;
    #1;
    chk("async_busy", int'(busy_o), 0);
    chk("async_arr_valid", int'(arr_valid_o), 0);
    chk("async_arr_reset", int'(arr_reset_o), 1);
    @(negedge clk_i);
    reset_i = 1'b0;
    run_job(1'b0, 1'b0, 1'b0);

`ifdef MM_SEQ_TIMEOUT_EN
    begin
      int cyc;
      bit seen_done;
      arr_hold = 1'b1;
      seen_done = 1'b0;
      @(negedge clk_i);
      start_i = 1'b1;
      cyc = 0;
      while (!error_o && cyc < 100) begin
        @(negedge clk_i);
        cyc++;
        start_i = 1'b0;
        if (done_o) seen_done = 1'b1;
      end
      chk("timeout_error_cycle", cyc, 6 + 4*N);
      cyc = 0;
      while (busy_o && cyc < 5) begin
        @(negedge clk_i);
        cyc++;
        if (done_o) seen_done = 1'b1;
      end
      chk("timeout_busy_drops", int'(busy_o), 0);
      chk("timeout_no_done", int'(seen_done), 0);
      arr_hold = 1'b0;
      run_job(1'b0, 1'b0, 1'b0);
      chk("error_sticky", int'(error_o), 1);
    end
`else
    chk("error_tied_low", int'(error_o), 0);
`endif

    for (int t = 0; t < 3; t++) begin
      rand_ops(); load_ops();
      run_job(t[0], 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
